// File: rtl/sleep_wdt_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and prescaler helper for the sleep/watchdog sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sleep_wdt_ctrl_pkg;

  // Instruction encodings decoded from the execute-stage IR
  localparam logic [11:0] INST_SLEEP  = 12'h003;
  localparam logic [11:0] INST_CLRWDT = 12'h004;

  // Sequencer state encoding
  localparam int SWC_STATE_BITS = 2;
  typedef enum logic [SWC_STATE_BITS-1:0] {
    SWC_RUN     = 2'd0,
    SWC_SLEEP   = 2'd1,
    SWC_WDT_RST = 2'd2
  } swc_state_e;

  // Prescaler width: PS up to 7 gives a divide-by-128 period
  localparam int PRE_WIDTH = 7;

  // Low-bit mask whose all-ones value marks the last cycle of a 2^ps period
  function automatic logic [PRE_WIDTH-1:0] ps_mask(input logic [2:0] ps);
    logic [7:0] v_full;
    v_full = (8'd1 << ps) - 8'd1;
    return v_full[PRE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sleep_wdt_ctrl_if.sv
// Bundles the instruction/configuration inputs and the core-control outputs of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or one-cycle strobes.
interface sleep_wdt_ctrl_if;
  logic [11:0] instIn;
  logic        instValid;
  logic        wdtEnIn;
  logic [3:0]  optionIn;
  logic        coreEn;
  logic        wdtResetOut;
  logic        toOut;
  logic        pdOut;
  logic        sleepingOut;

  // Core/environment side: drives instruction and config, observes control outputs
  modport master (
    output instIn, instValid, wdtEnIn, optionIn,
    input  coreEn, wdtResetOut, toOut, pdOut, sleepingOut
  );

  // Sequencer side
  modport slave (
    input  instIn, instValid, wdtEnIn, optionIn,
    output coreEn, wdtResetOut, toOut, pdOut, sleepingOut
  );
endinterface

// File: rtl/sleep_wdt_ctrl_wdt_timer.sv
// Watchdog prescaler + base counter; o_timeout pulses on the tick where the counter is all-ones.
// Latency: timeout is combinational from registered count in the same cycle as the final tick.
// Backpressure: i_hold freezes both prescaler and counter; WDT_PRESCALE_EN builds the prescaler.
module sleep_wdt_ctrl_wdt_timer
  import sleep_wdt_ctrl_pkg::*;
#(
  parameter int WDT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_hold,
  input  logic [3:0] i_option,
  output logic       o_timeout
);

  logic                 w_tick;
  logic                 w_fire;
  logic [WDT_WIDTH-1:0] r_cnt;

`ifdef WDT_PRESCALE_EN
  logic [PRE_WIDTH-1:0] r_pre;
  logic [PRE_WIDTH-1:0] w_mask;
  logic                 w_pre_wrap;

  // A new PS value only matters when the masked prescaler bits next reach all-ones
  assign w_mask     = ps_mask(i_option[2:0]);
  assign w_pre_wrap = ((r_pre & w_mask) == w_mask);
  assign w_tick     = i_option[3] ? w_pre_wrap : 1'b1;

  // Free-running prescaler; restarts at each wrap, never cleared by an OPTION change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (i_clear || !i_enable) begin
      r_pre <= '0;
    end else if (!i_hold) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 7'd1;
    end
  end
`else
  logic w_unused_option;
  assign w_unused_option = ^i_option;
  assign w_tick          = 1'b1;
`endif

  assign w_fire    = i_enable && !i_hold && w_tick;
  assign o_timeout = w_fire && !i_clear && (&r_cnt);

  // Base counter: cleared by SLEEP/CLRWDT or when disabled, wraps to 0 on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (w_fire) begin
      r_cnt <= r_cnt + WDT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sleep_wdt_ctrl.sv
// Sleep/watchdog sequencer: decodes SLEEP/CLRWDT, gates the core, issues watchdog core reset, owns TO/PD.
// Latency: all outputs registered, one cycle after the accepted instruction or timeout tick.
// Backpressure: instructions ignored outside RUN; optional prescaler built under WDT_PRESCALE_EN.
module sleep_wdt_ctrl
  import sleep_wdt_ctrl_pkg::*;
#(
  parameter int WDT_WIDTH  = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sleep_wdt_ctrl_if.slave bus
);

  swc_state_e r_state;
  swc_state_e w_state_nxt;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_nxt;

  logic w_accept;
  logic w_acc_sleep;
  logic w_acc_clr;
  logic w_timeout;

  logic r_core_en, r_wdt_rst, r_to, r_pd, r_sleeping;
  logic w_core_en_nxt, w_wdt_rst_nxt, w_to_nxt, w_pd_nxt, w_sleeping_nxt;

  assign w_accept    = bus.instValid && (r_state == SWC_RUN);
  assign w_acc_sleep = w_accept && (bus.instIn == INST_SLEEP);
  assign w_acc_clr   = w_accept && (bus.instIn == INST_CLRWDT);

  sleep_wdt_ctrl_wdt_timer #(
    .WDT_WIDTH (WDT_WIDTH)
  ) u_wdt_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_acc_sleep || w_acc_clr),
    .i_enable  (bus.wdtEnIn),
    .i_hold    (r_state == SWC_WDT_RST),
    .i_option  (bus.optionIn),
    .o_timeout (w_timeout)
  );

  // State, reset-hold counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SWC_RUN;
      r_hold_cnt <= '0;
      r_core_en  <= 1'b1;
      r_wdt_rst  <= 1'b0;
      r_to       <= 1'b1;
      r_pd       <= 1'b1;
      r_sleeping <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_core_en  <= w_core_en_nxt;
      r_wdt_rst  <= w_wdt_rst_nxt;
      r_to       <= w_to_nxt;
      r_pd       <= w_pd_nxt;
      r_sleeping <= w_sleeping_nxt;
    end
  end

  // Next state: accepted instructions beat a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      SWC_RUN: begin
        if (w_acc_sleep) begin
          w_state_nxt = SWC_SLEEP;
        end else if (!w_acc_clr && w_timeout) begin
          w_state_nxt = SWC_WDT_RST;
          w_hold_nxt  = 4'(RST_CYCLES - 1);
        end
      end
      SWC_SLEEP: begin
        if (w_timeout) begin
          w_state_nxt = SWC_WDT_RST;
          w_hold_nxt  = 4'(RST_CYCLES - 1);
        end
      end
      SWC_WDT_RST: begin
        if (r_hold_cnt == 4'd0) begin
          w_state_nxt = SWC_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = SWC_RUN;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Output decode from next state; TO/PD update on accept or timeout only
  always_comb begin
    w_core_en_nxt  = (w_state_nxt == SWC_RUN);
    w_wdt_rst_nxt  = (w_state_nxt == SWC_WDT_RST);
    w_sleeping_nxt = (w_state_nxt == SWC_SLEEP);
    w_to_nxt       = r_to;
    w_pd_nxt       = r_pd;
    if (w_acc_sleep) begin
      w_to_nxt = 1'b1;
      w_pd_nxt = 1'b0;
    end else if (w_acc_clr) begin
      w_to_nxt = 1'b1;
      w_pd_nxt = 1'b1;
    end else if (w_timeout) begin
      w_to_nxt = 1'b0;
    end
  end

  assign bus.coreEn      = r_core_en;
  assign bus.wdtResetOut = r_wdt_rst;
  assign bus.toOut       = r_to;
  assign bus.pdOut       = r_pd;
  assign bus.sleepingOut = r_sleeping;

endmodule
